// File: rtl/lfsr_bank.sv
// ============================================================================
// lfsr_bank : bank of independent XNOR-feedback LFSRs with seed loading,
//             warm-up tracking and all-ones lock-state recovery.
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr_bank #(
    parameter int              WIDTH      = 25,
    parameter int              CHANNELS   = 4,
    parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(25'h0000009),
    parameter int              STEPS      = 1,
    parameter logic [63:0]     RESET_SEED = 64'd1,
    parameter int              WARMUP     = 8,
    localparam int             CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CW-1:0]             load_chan,
    input  logic [WIDTH-1:0]          load_seed,
    input  logic                      clear_lockup,
    output logic [CHANNELS*WIDTH-1:0] pseudo_rand,
    output logic [CHANNELS-1:0]       rand_valid,
    output logic [CHANNELS-1:0]       lockup
);

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < STEPS; i++) begin
            v = {~^(v & TAP_MASK), v[WIDTH-1:1]};
        end
        return v;
    endfunction

    logic r_load_ready;
    logic w_take;

    assign w_take     = load_valid & r_load_ready;
    assign load_ready = r_load_ready;

    // Ready drops for exactly one cycle after each accepted transfer.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_load_ready <= 1'b1;
        end else begin
            r_load_ready <= ~w_take;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        localparam logic [WIDTH-1:0] C_SEED = WIDTH'(RESET_SEED + 64'(c));

        logic [WIDTH-1:0] r_state;
        logic [7:0]       r_cnt;
        logic             r_lock;
        logic             w_hit;
        logic             w_set;

        // Out-of-range channel indices match no channel and so change nothing.
        assign w_hit = w_take && (load_chan == CW'(c));
        assign w_set = w_hit ? (&load_seed) : (Enable && (&r_state));

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                r_state <= C_SEED;
                r_cnt   <= 8'd0;
                r_lock  <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_state <= (&load_seed) ? C_SEED : load_seed;
                    r_cnt   <= 8'd0;
                end else if (Enable) begin
                    r_state <= (&r_state) ? C_SEED : f_step(r_state);
                    if (r_cnt != 8'(WARMUP)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                r_lock <= w_set | (r_lock & ~clear_lockup);
            end
        end

        assign pseudo_rand[c*WIDTH +: WIDTH] = r_state;
        assign rand_valid[c]                 = (r_cnt == 8'(WARMUP));
        assign lockup[c]                     = r_lock;
    end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_bank.sv
// Testbench for lfsr_bank: directed vectors, literal expectations and a
// per-cycle comparison against a behavioural model of the default bank.
`default_nettype none

module tb_lfsr_bank;

    logic         Clk;
    logic         Reset;
    logic         Enable;
    logic         load_valid;
    logic         load_ready;
    logic [1:0]   load_chan;
    logic [24:0]  load_seed;
    logic         clear_lockup;
    logic [99:0]  pseudo_rand;
    logic [3:0]   rand_valid;
    logic [3:0]   lockup;

    logic         b_en;
    logic         b_lv;
    logic         b_rdy;
    logic [1:0]   b_chan;
    logic [24:0]  b_seed;
    logic [74:0]  b_pr;
    logic [2:0]   b_rv;
    logic [2:0]   b_lk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    lfsr_bank u_dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_chan(load_chan), .load_seed(load_seed),
        .clear_lockup(clear_lockup), .pseudo_rand(pseudo_rand),
        .rand_valid(rand_valid), .lockup(lockup)
    );

    lfsr_bank #(.STEPS(2), .CHANNELS(3)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .Enable(b_en),
        .load_valid(b_lv), .load_ready(b_rdy),
        .load_chan(b_chan), .load_seed(b_seed),
        .clear_lockup(1'b0), .pseudo_rand(b_pr),
        .rand_valid(b_rv), .lockup(b_lk)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Behavioural model of the default-parameter bank.
    logic [24:0] m_state [4];
    int          m_cnt   [4];
    logic [3:0]  m_lock;
    logic        m_ready;
    logic        m_take;
    logic        m_set;

    function automatic logic [24:0] mstep(input logic [24:0] s);
        logic fb;
        fb = (($countones(s & 25'h0000009) % 2) == 0);
        return (s >> 1) | ({24'd0, fb} << 24);
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int c = 0; c < 4; c++) begin
                m_state[c] = 25'(c + 1);
                m_cnt[c]   = 0;
            end
            m_lock  = 4'b0;
            m_ready = 1'b1;
        end else begin
            m_take = load_valid && m_ready;
            for (int c = 0; c < 4; c++) begin
                m_set = 1'b0;
                if (m_take && (int'(load_chan) == c)) begin
                    if (load_seed == 25'h1FFFFFF) begin
                        m_state[c] = 25'(c + 1);
                        m_set      = 1'b1;
                    end else begin
                        m_state[c] = load_seed;
                    end
                    m_cnt[c] = 0;
                end else if (Enable) begin
                    if (m_state[c] == 25'h1FFFFFF) begin
                        m_state[c] = 25'(c + 1);
                        m_set      = 1'b1;
                    end else begin
                        m_state[c] = mstep(m_state[c]);
                    end
                    if (m_cnt[c] < 8) m_cnt[c]++;
                end
                m_lock[c] = m_set | (m_lock[c] & ~clear_lockup);
            end
            m_ready = !m_take;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            logic [3:0] e_rv;
            for (int c = 0; c < 4; c++) e_rv[c] = (m_cnt[c] == 8);
            chk("model_state", 128'(pseudo_rand),
                128'({m_state[3], m_state[2], m_state[1], m_state[0]}));
            chk("model_rand_valid", 128'(rand_valid), 128'(e_rv));
            chk("model_lockup", 128'(lockup), 128'(m_lock));
            chk("model_load_ready", 128'(load_ready), 128'(m_ready));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Enable = 1'b0; load_valid = 1'b0; load_chan = 2'd0;
        load_seed = 25'd0; clear_lockup = 1'b0;
        b_en = 1'b0; b_lv = 1'b0; b_chan = 2'd0; b_seed = 25'd0;

        tick();
        cmp_en = 1;
        tick();
        chk("reset_state", 128'(pseudo_rand), 128'({25'd4, 25'd3, 25'd2, 25'd1}));
        chk("reset_valid", 128'(rand_valid), 128'(4'b0000));
        chk("reset_lockup", 128'(lockup), 128'(4'b0000));
        chk("reset_ready", 128'(load_ready), 128'(1'b1));

        Reset = 1'b1;
        Enable = 1'b1; b_en = 1'b1;
        tick();
        b_en = 1'b0;
        chk("ch0_step1", 128'(pseudo_rand[24:0]), 128'(25'h0000000));
        chk("ch1_step1", 128'(pseudo_rand[49:25]), 128'(25'h1000001));
        chk("steps2_state", 128'(b_pr), 128'({25'h0000000, 25'h0800000, 25'h1000000}));

        b_lv = 1'b1; b_chan = 2'd3; b_seed = 25'h0AAAAAA;
        tick();
        b_lv = 1'b0;
        chk("ch0_step2", 128'(pseudo_rand[24:0]), 128'(25'h1000000));
        chk("oor_load_nochange", 128'(b_pr), 128'({25'h0000000, 25'h0800000, 25'h1000000}));
        chk("oor_load_ready", 128'(b_rdy), 128'(1'b0));
        chk("oor_load_lockup", 128'(b_lk), 128'(3'b000));

        for (int i = 3; i <= 8; i++) begin
            tick();
            if (i == 7) chk("warmup_7th", 128'(rand_valid), 128'(4'b0000));
            if (i == 8) chk("warmup_8th", 128'(rand_valid), 128'(4'b1111));
        end

        Enable = 1'b0;
        load_valid = 1'b1; load_chan = 2'd1; load_seed = 25'h0123456;
        tick();
        load_valid = 1'b0;
        chk("load_ch1", 128'(pseudo_rand[49:25]), 128'(25'h0123456));
        Enable = 1'b1;
        repeat (3) tick();
        Enable = 1'b0;
        chk("warmup_after_load", 128'(rand_valid), 128'(4'b1101));

        load_valid = 1'b1; load_chan = 2'd2; load_seed = 25'h1FFFFFF;
        tick();
        load_valid = 1'b0;
        chk("lock_load_state", 128'(pseudo_rand[74:50]), 128'(25'h0000003));
        chk("lock_load_flag", 128'(lockup), 128'(4'b0100));
        clear_lockup = 1'b1;
        tick();
        clear_lockup = 1'b0;
        chk("lock_clear", 128'(lockup), 128'(4'b0000));

        load_valid = 1'b1; load_chan = 2'd3; load_seed = 25'h1FFFFFF; clear_lockup = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("lock_set_wins", 128'(lockup), 128'(4'b1000));
        tick();
        clear_lockup = 1'b0;

        load_valid = 1'b1; load_chan = 2'd0;
        load_seed = 25'h0000111; chk("ready_c1", 128'(load_ready), 128'(1'b1)); tick();
        load_seed = 25'h0000222; chk("ready_c2", 128'(load_ready), 128'(1'b0)); tick();
        load_seed = 25'h0000333; chk("ready_c3", 128'(load_ready), 128'(1'b1)); tick();
        load_seed = 25'h0000444; chk("ready_c4", 128'(load_ready), 128'(1'b0)); tick();
        load_valid = 1'b0;
        chk("held_valid_ch0", 128'(pseudo_rand[24:0]), 128'(25'h0000333));

        load_valid = 1'b1; load_chan = 2'd0; load_seed = 25'h0ABCDEF; Enable = 1'b1;
        tick();
        load_valid = 1'b0; Enable = 1'b0;
        chk("load_enable_ch0", 128'(pseudo_rand[24:0]), 128'(25'h0ABCDEF));
        tick();

        load_valid = 1'b1; load_chan = 2'd2; load_seed = 25'h0555555;
        #2 Reset = 1'b0;
        tick();
        chk("midload_reset", 128'(pseudo_rand), 128'({25'd4, 25'd3, 25'd2, 25'd1}));
        Reset = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("post_reset_load", 128'(pseudo_rand[74:50]), 128'(25'h0555555));
        chk("post_reset_ready", 128'(load_ready), 128'(1'b0));
        tick();

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
